// File: rtl/round_controller.sv
// ============================================================================
// Module   : round_controller
// Purpose  : Game-round sequencer sitting after the countdown timer.
//            Sequences IDLE -> ARM -> PLAY -> OVER, owns the timer reset,
//            counts player hits into a saturating 2-digit BCD score and
//            decodes both digits to active-low 7-segment patterns.
// Ports    : clock_i      system clock
//            reset_i      synchronous active-high reset
//            start_i      start button level (rising edge used)
//            hit_i        hit sensor level (rising edge used)
//            time_up_i    countdown timer expired flag
//            timer_rst_o  holds the countdown timer at its initial count
//            playing_o    high while a round is running
//            game_over_o  high once the round has ended
//            score_*_o    BCD score digits
//            seg_*_o      7-seg {g,f,e,d,c,b,a}, active low
// Option   : BEST_SCORE_EN adds best_tens_o/best_ones_o (best score kept
//            across rounds) and new_record_o (1-cycle pulse on a new best).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module round_controller #(
  parameter int HOLDOFF   = 4,
  parameter int MAX_SCORE = 99
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       hit_i,
  input  logic       time_up_i,
  output logic       timer_rst_o,
  output logic       playing_o,
  output logic       game_over_o,
  output logic [3:0] score_tens_o,
  output logic [3:0] score_ones_o,
  output logic [6:0] seg_tens_o,
  output logic [6:0] seg_ones_o
`ifdef BEST_SCORE_EN
  ,
  output logic [3:0] best_tens_o,
  output logic [3:0] best_ones_o,
  output logic       new_record_o
`endif
);

  localparam int         HO_W     = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [3:0] MAX_TENS = 4'(MAX_SCORE / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_SCORE % 10);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_PLAY = 2'd2,
    S_OVER = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              arm_cnt_q, arm_cnt_d;
  logic [HO_W-1:0]   holdoff_q, holdoff_d;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        ones_q, ones_d;
  logic              start_q, hit_q;
  logic              start_edge, hit_edge;

  assign start_edge = start_i & ~start_q;
  assign hit_edge   = hit_i & ~hit_q;

  // The previous-level registers follow the inputs even while reset is
  // held, so a button already pressed when reset releases is not seen as
  // a fresh edge (with inputs low during reset they clear to 0).
  always_ff @(posedge clock_i) begin
    start_q <= start_i;
    hit_q   <= hit_i;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      arm_cnt_q <= 1'b0;
      holdoff_q <= '0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
      holdoff_q <= holdoff_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    arm_cnt_d   = arm_cnt_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    holdoff_d   = (holdoff_q != '0) ? holdoff_q - HO_W'(1) : holdoff_q;
    timer_rst_o = 1'b1;
    playing_o   = 1'b0;
    game_over_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d   = S_ARM;
          arm_cnt_d = 1'b0;
        end
      end
      S_ARM: begin
        // Two-cycle arm window: score and holdoff are forced clear while
        // the timer is held in reset.
        tens_d    = 4'd0;
        ones_d    = 4'd0;
        holdoff_d = '0;
        arm_cnt_d = 1'b1;
        if (arm_cnt_q) state_d = S_PLAY;
      end
      S_PLAY: begin
        timer_rst_o = 1'b0;
        playing_o   = 1'b1;
        if (hit_edge && (holdoff_q == '0)) begin
          holdoff_d = HO_W'(HOLDOFF);
          // At the ceiling the hit is consumed (holdoff reloads) but the
          // score does not move.
          if (!((tens_q == MAX_TENS) && (ones_q == MAX_ONES))) begin
            if (ones_q == 4'd9) begin
              ones_d = 4'd0;
              tens_d = tens_q + 4'd1;
            end else begin
              ones_d = ones_q + 4'd1;
            end
          end
        end
        if (time_up_i) state_d = S_OVER;
      end
      S_OVER: begin
        game_over_o = 1'b1;
        if (start_edge) begin
          state_d   = S_ARM;
          arm_cnt_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign score_tens_o = tens_q;
  assign score_ones_o = ones_q;
  assign seg_tens_o   = seg7(tens_q);
  assign seg_ones_o   = seg7(ones_q);

`ifdef BEST_SCORE_EN
  logic [3:0] best_tens_q, best_ones_q;
  logic       new_record_q;

  // The comparison uses the next score so a hit landing in the same cycle
  // as time-up is part of the final result. Packed BCD orders numerically.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      best_tens_q  <= 4'd0;
      best_ones_q  <= 4'd0;
      new_record_q <= 1'b0;
    end else begin
      new_record_q <= 1'b0;
      if ((state_q == S_PLAY) && time_up_i &&
          ({tens_d, ones_d} > {best_tens_q, best_ones_q})) begin
        best_tens_q  <= tens_d;
        best_ones_q  <= ones_d;
        new_record_q <= 1'b1;
      end
    end
  end

  assign best_tens_o  = best_tens_q;
  assign best_ones_o  = best_ones_q;
  assign new_record_o = new_record_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_round_controller.sv
// ============================================================================
// Module   : tb_round_controller
// Purpose  : Self-checking bench for round_controller. Directed round
//            scenarios followed by random stimulus, every cycle compared
//            against a behavioural model of the round rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_round_controller;

  localparam int HOLDOFF   = 4;
  localparam int MAX_SCORE = 99;
  localparam int M_IDLE = 0, M_ARM = 1, M_PLAY = 2, M_OVER = 3;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1, start_i = 1'b0, hit_i = 1'b0, time_up_i = 1'b0;
  logic       timer_rst_o, playing_o, game_over_o;
  logic [3:0] score_tens_o, score_ones_o;
  logic [6:0] seg_tens_o, seg_ones_o;
`ifdef BEST_SCORE_EN
  logic [3:0] best_tens_o, best_ones_o;
  logic       new_record_o;
`endif

  round_controller #(.HOLDOFF(HOLDOFF), .MAX_SCORE(MAX_SCORE)) dut (
    .clock_i      (clk),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .hit_i        (hit_i),
    .time_up_i    (time_up_i),
    .timer_rst_o  (timer_rst_o),
    .playing_o    (playing_o),
    .game_over_o  (game_over_o),
    .score_tens_o (score_tens_o),
    .score_ones_o (score_ones_o),
    .seg_tens_o   (seg_tens_o),
    .seg_ones_o   (seg_ones_o)
`ifdef BEST_SCORE_EN
    ,
    .best_tens_o  (best_tens_o),
    .best_ones_o  (best_ones_o),
    .new_record_o (new_record_o)
`endif
  );

  always #5 clk = ~clk;

  logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000};

  int n_pass = 0;
  int n_total = 0;

  // Reference model state: round phase, plain integer score and holdoff.
  int m_mode = M_IDLE, m_score = 0, m_hold = 0, m_arm_left = 0, m_best = 0;
  bit m_newrec = 1'b0, m_ps = 1'b0, m_ph = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_step(input bit s, input bit h, input bit t, input bit r);
    bit se, he;
    int old_hold;
    if (r) begin
      m_mode = M_IDLE; m_score = 0; m_hold = 0; m_best = 0; m_newrec = 0;
      m_ps = s; m_ph = h;
      return;
    end
    se = s && !m_ps;
    he = h && !m_ph;
    m_ps = s; m_ph = h;
    m_newrec = 0;
    old_hold = m_hold;
    if (m_hold > 0) m_hold--;
    case (m_mode)
      M_IDLE: if (se) begin m_mode = M_ARM; m_arm_left = 2; end
      M_ARM: begin
        m_score = 0; m_hold = 0; m_arm_left--;
        if (m_arm_left == 0) m_mode = M_PLAY;
      end
      M_PLAY: begin
        if (he && old_hold == 0) begin
          if (m_score < MAX_SCORE) m_score++;
          m_hold = HOLDOFF;
        end
        if (t) begin
          m_mode = M_OVER;
          if (m_score > m_best) begin m_best = m_score; m_newrec = 1; end
        end
      end
      default: if (se) begin m_mode = M_ARM; m_arm_left = 2; end
    endcase
  endtask

  // One clock: apply inputs, advance model on the edge, compare 1 time unit later.
  task automatic cyc(input bit s, input bit h, input bit t);
    logic [24:0] obs, exp;
    start_i = s; hit_i = h; time_up_i = t;
    @(posedge clk);
    model_step(s, h, t, reset_i);
    #1;
    obs = {timer_rst_o, playing_o, game_over_o, score_tens_o, score_ones_o,
           seg_tens_o, seg_ones_o};
    exp = {(m_mode != M_PLAY), (m_mode == M_PLAY), (m_mode == M_OVER),
           4'(m_score / 10), 4'(m_score % 10), SEG[m_score / 10], SEG[m_score % 10]};
    check("cycle_outputs", 32'(obs), 32'(exp));
`ifdef BEST_SCORE_EN
    check("best_score", {23'd0, best_tens_o, best_ones_o, new_record_o},
          {23'd0, 4'(m_best / 10), 4'(m_best % 10), m_newrec});
`endif
  endtask

  task automatic hits(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      cyc(0, 1, 0);
      for (int j = 1; j < gap; j++) cyc(0, 0, 0);
    end
  endtask

  task automatic begin_round();
    cyc(1, 0, 0);
    check("arm1_timer_rst", {31'd0, timer_rst_o}, 32'd1);
    check("arm1_playing", {31'd0, playing_o}, 32'd0);
    cyc(0, 0, 0);
    check("arm2_timer_rst", {31'd0, timer_rst_o}, 32'd1);
    cyc(0, 0, 0);
    check("play_entry", {29'd0, playing_o, timer_rst_o, game_over_o}, {29'd0, 3'b100});
    check("play_score00", {24'd0, score_tens_o, score_ones_o}, 32'h00);
    check("play_seg_ones", {25'd0, seg_ones_o}, {25'd0, 7'b1000000});
  endtask

  task automatic end_round();
    cyc(0, 0, 1);
    cyc(0, 0, 0);
  endtask

  initial begin
    // Reset held three cycles.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    check("reset_state", {25'd0, timer_rst_o, playing_o, game_over_o, score_tens_o},
          {25'd0, 3'b100, 4'd0});
    check("reset_seg", {18'd0, seg_tens_o, seg_ones_o}, {18'd0, 7'b1000000, 7'b1000000});
    reset_i = 1'b0;
    cyc(0, 0, 0);

    // Round 1: spaced hits all count, tightly spaced hits thinned by holdoff.
    begin_round();
    hits(12, 6);
    check("score12", {24'd0, score_tens_o, score_ones_o}, 32'h12);
    check("seg12", {18'd0, seg_tens_o, seg_ones_o}, {18'd0, 7'b1111001, 7'b0100100});
    hits(9, 2);
    check("holdoff_thinning", {24'd0, score_tens_o, score_ones_o}, 32'h15);
    end_round();
    hits(2, 5);
    check("over_hits_ignored", {24'd0, score_tens_o, score_ones_o}, 32'h15);
    cyc(0, 0, 0);
    check("over_timer_rst", {30'd0, game_over_o, timer_rst_o}, 32'h3);

    // Round 2: BCD carry and saturation.
    begin_round();
    hits(9, 5);
    check("score09", {24'd0, score_tens_o, score_ones_o}, 32'h09);
    hits(1, 5);
    check("carry_to10", {24'd0, score_tens_o, score_ones_o}, 32'h10);
    hits(89, 5);
    check("score99", {24'd0, score_tens_o, score_ones_o}, 32'h99);
    hits(3, 5);
    check("saturate99", {24'd0, score_tens_o, score_ones_o}, 32'h99);
    end_round();

    // Round 3: hit edge and time_up in the same cycle.
    begin_round();
    hits(5, 5);
    cyc(0, 1, 1);
    check("hit_with_timeup", {24'd0, score_tens_o, score_ones_o}, 32'h06);
    check("timeup_latency", {30'd0, game_over_o, timer_rst_o}, 32'h3);
    cyc(0, 0, 0);
    hits(3, 5);
    check("frozen06", {24'd0, score_tens_o, score_ones_o}, 32'h06);

    // Round 4: reset in the middle of play.
    begin_round();
    hits(7, 5);
    check("score07", {24'd0, score_tens_o, score_ones_o}, 32'h07);
    reset_i = 1'b1;
    cyc(0, 0, 0);
    reset_i = 1'b0;
    check("mid_reset", {24'd0, timer_rst_o, playing_o, game_over_o, 1'b0,
                        score_tens_o, score_ones_o}, {24'd0, 4'b1000, 8'h00});
    cyc(0, 0, 0);

    // Best-score sequence 07, 04, 11.
    begin_round(); hits(7, 5); cyc(0, 0, 1);
`ifdef BEST_SCORE_EN
    check("rec_r1", {23'd0, best_tens_o, best_ones_o, new_record_o}, {23'd0, 8'h07, 1'b1});
`endif
    cyc(0, 0, 0);
    begin_round(); hits(4, 5); cyc(0, 0, 1);
`ifdef BEST_SCORE_EN
    check("rec_r2", {23'd0, best_tens_o, best_ones_o, new_record_o}, {23'd0, 8'h07, 1'b0});
`endif
    cyc(0, 0, 0);
    begin_round(); hits(11, 5); cyc(0, 0, 1);
`ifdef BEST_SCORE_EN
    check("rec_r3", {23'd0, best_tens_o, best_ones_o, new_record_o}, {23'd0, 8'h11, 1'b1});
`endif
    cyc(0, 0, 0);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      reset_i = ($urandom_range(0, 499) == 0);
      cyc(($urandom_range(0, 11) == 0), $urandom_range(0, 1) == 1,
          ($urandom_range(0, 40) == 0));
    end
    reset_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/round_controller.md
Name: round_controller

Overview:
Game-round sequencer directly downstream of the countdown timer; consumes its time-up flag. Owns the timer's reset, gates player hits into a 2-digit BCD score and drives two 7-segment score digits. FSM sequences IDLE -> ARM -> PLAY -> OVER, re-arming on a start press.

Parameters:
HOLDOFF, 4, cycles after an accepted hit during which further hit edges are ignored (0 = no holdoff)
MAX_SCORE, 99, saturation value of the BCD score (must be 1..99)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  start button level; rising edge detected internally
hit  input  1  zombie-hit level; rising edge detected internally
time_up  input  1  countdown-timer flag; high = time expired
timer_rst  output  1  drives countdown timer reset; high holds timer at initial count
playing  output  1  high while in PLAY
game_over  output  1  high while in OVER
score_tens  output  4  BCD tens digit
score_ones  output  4  BCD ones digit
seg_tens  output  7  7-seg for score_tens
seg_ones  output  7  7-seg for score_ones

Behaviour:
- Reset (sync, high): state=IDLE, score=00, holdoff=0, edge-detect regs=0; timer_rst=1, playing=0, game_over=0, seg_* show "0".
- Edge detect: start_q/hit_q register previous level; edge = level & ~q. A level already high at reset release produces no edge.
- IDLE: timer_rst=1; score holds its value. start edge -> ARM.
- ARM: exactly 2 cycles (internal counter); timer_rst=1; score cleared to 00 on first ARM cycle; holdoff cleared. -> PLAY. time_up ignored in ARM.
- PLAY: timer_rst=0, playing=1. Hit accepted when hit edge & holdoff==0: score += 1 in BCD (ones 9 -> 0 with tens +1); at MAX_SCORE score holds (saturates) and the hit is still consumed. Accepted hit loads holdoff=HOLDOFF; holdoff decrements to 0 each cycle. time_up=1 -> OVER. Same cycle hit edge + time_up: hit counts, then OVER. start edges ignored.
- OVER: timer_rst=1, game_over=1; score frozen. start edge -> ARM. hit ignored.
- Latency: hit edge in cycle N -> score visible cycle N+1; time_up in cycle N -> game_over/timer_rst high cycle N+1.
- seg_*: combinational decode of registered BCD; active-low, bit order {g,f,e,d,c,b,a}: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000; codes 10-15 = 1111111 (blank).
- Reset mid-round: immediate return to IDLE, score 00, outputs at reset values next cycle.

Optional Feature:
BEST_SCORE_EN: defined -> extra outputs best_tens[3:0], best_ones[3:0] (reset 00) and new_record (1-cycle pulse). On PLAY->OVER transition, if score > best, best <= score and new_record=1 on first OVER cycle. best survives ARM/rounds; cleared only by reset. Undefined -> ports and logic absent; all other behaviour identical.

Test Plan:
- Reset held 3 cycles, start pulsed -> 2 ARM cycles with timer_rst=1, then playing=1, timer_rst=0, score 00, seg_ones=1000000.
- PLAY, HOLDOFF=4: 12 hit pulses spaced 6 cycles -> score 12 (tens=1, ones=2), seg_tens=1111001, seg_ones=0100100; pulses spaced 2 cycles -> only every third counts.
- Score 09 + hit -> 10 (ones wraps, tens increments); score 99 + hit -> stays 99.
- time_up and hit edge same cycle at score 05 -> score 06, game_over=1, timer_rst=1 next cycle; later hits leave 06.
- OVER + start -> ARM clears score to 00, PLAY resumes; reset asserted mid-PLAY at score 07 -> IDLE, score 00, timer_rst=1.
- BEST_SCORE_EN: rounds scoring 07 then 04 then 11 -> best 07, 07, 11; new_record pulses after rounds 1 and 3 only.
